// File: rtl/spinner_accum_pkg.sv
// rtl/spinner_accum_pkg.sv - shared constants, channel state encoding and clamp helper
package spinner_accum_pkg;

  localparam int DELTA_LSB = 0;
  localparam int DELTA_MSB = 7;
  localparam int TOG_BIT   = 8;
  localparam int SLOT_W    = 16;

  localparam int VEL_MAX = 127;
  localparam int VEL_MIN = -128;
  localparam int CNT_MAX = 255;

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } chan_state_e;

  function automatic logic [7:0] clamp8(input logic signed [31:0] v);
    if (v > VEL_MAX) begin
      return 8'h7F;
    end else if (v < VEL_MIN) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/spinner_accum_if.sv
// rtl/spinner_accum_if.sv - spinner input streams and per-frame result vectors
interface spinner_accum_if #(
  parameter int DEVICES = 6,
  parameter int POS_W   = 16
);
  import spinner_accum_pkg::*;

  logic [SLOT_W*DEVICES-1:0] spinner;
  logic                      vs;
  logic [DEVICES-1:0]        clear;
  logic [POS_W*DEVICES-1:0]  position;
  logic [8*DEVICES-1:0]      velocity;
  logic [8*DEVICES-1:0]      evcount;
  logic                      frame_strobe;

  modport master (
    output spinner, vs, clear,
    input  position, velocity, evcount, frame_strobe
  );

  modport slave (
    input  spinner, vs, clear,
    output position, velocity, evcount, frame_strobe
  );

endinterface

// File: rtl/spinner_accum_chan.sv
// rtl/spinner_accum_chan.sv - one spinner channel: arm FSM, position, frame sum/count and latch
module spinner_chan
  import spinner_accum_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int ACC_W = 12
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [7:0]       delta_i,
  input  logic             tog_i,
  input  logic             clear_i,
  input  logic             boundary_i,
  output logic [POS_W-1:0] position_o,
  output logic [7:0]       velocity_o,
  output logic [7:0]       evcount_o
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  chan_state_e              state_q, state_d;
  logic                     prev_tog_q;
  logic [POS_W-1:0]         pos_q, pos_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               vel_q, vel_d;
  logic [7:0]               evc_q, evc_d;

  logic                     evt;
  logic [POS_W-1:0]         pos_base;
  logic signed [ACC_W-1:0]  acc_base;
  logic [7:0]               cnt_base;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_sat;

  always_comb begin
    state_d  = state_q;
    evt      = 1'b0;
    pos_base = pos_q;
    acc_base = acc_q;
    cnt_base = cnt_q;
    acc_sum  = '0;
    acc_sat  = '0;
    pos_d    = pos_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    vel_d    = vel_q;
    evc_d    = evc_q;

    // ARM swallows whatever toggle level is present at release
    case (state_q)
      ARM:     state_d = RUN;
      RUN:     evt = (tog_i != prev_tog_q);
      default: state_d = ARM;
    endcase

    // clear takes effect before the same-cycle delta is added
    pos_base = clear_i ? '0 : pos_q;
    pos_d    = evt ? pos_base + {{(POS_W-8){delta_i[7]}}, delta_i} : pos_base;

    // at a boundary the finished frame is latched and a same-cycle event opens the new one
    if (boundary_i) begin
      vel_d    = clamp8(32'(acc_q));
      evc_d    = cnt_q;
      acc_base = '0;
      cnt_base = '0;
    end

    acc_sum = {acc_base[ACC_W-1], acc_base} + {{(ACC_W-7){delta_i[7]}}, delta_i};
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sat = acc_sum[ACC_W-1:0];
    end

    acc_d = evt ? acc_sat : acc_base;
    if (evt && (cnt_base != 8'(CNT_MAX))) begin
      cnt_d = cnt_base + 8'd1;
    end else begin
      cnt_d = cnt_base;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARM;
      prev_tog_q <= 1'b0;
      pos_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      vel_q      <= '0;
      evc_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_tog_q <= tog_i;
      pos_q      <= pos_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      vel_q      <= vel_d;
      evc_q      <= evc_d;
    end
  end

  assign position_o = pos_q;
  assign velocity_o = vel_q;
  assign evcount_o  = evc_q;

endmodule

// File: rtl/spinner_accum.sv
// rtl/spinner_accum.sv - vsync framing and per-device spinner channel array
module spinner_accum
  import spinner_accum_pkg::*;
#(
  parameter int DEVICES = 6,
  parameter int POS_W   = 16,
  parameter int ACC_W   = 12
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  spinner_accum_if.slave bus
);

  logic vs_q;
  logic bnd_q;
  logic strobe_q;
  logic boundary;

  assign boundary = bus.vs & ~vs_q;

  // strobe trails the latch by one cycle so readers see settled results
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_q     <= 1'b0;
      bnd_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      vs_q     <= bus.vs;
      bnd_q    <= boundary;
      strobe_q <= bnd_q;
    end
  end

  assign bus.frame_strobe = strobe_q;

  for (genvar g = 0; g < DEVICES; g++) begin : g_chan
    logic unused_slot_hi;
    assign unused_slot_hi = ^bus.spinner[g*SLOT_W+TOG_BIT+1 +: SLOT_W-TOG_BIT-1];

    spinner_chan #(
      .POS_W (POS_W),
      .ACC_W (ACC_W)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .delta_i    (bus.spinner[g*SLOT_W+DELTA_LSB +: DELTA_MSB-DELTA_LSB+1]),
      .tog_i      (bus.spinner[g*SLOT_W+TOG_BIT]),
      .clear_i    (bus.clear[g]),
      .boundary_i (boundary),
      .position_o (bus.position[g*POS_W +: POS_W]),
      .velocity_o (bus.velocity[g*8 +: 8]),
      .evcount_o  (bus.evcount[g*8 +: 8])
    );
  end

endmodule

// File: tb/tb_spinner_accum.sv
// tb/tb_spinner_accum.sv - scoreboard bench for spinner_accum
module tb_spinner_accum;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  spinner_accum_if #(.DEVICES(6), .POS_W(16)) bus ();

  spinner_accum #(.DEVICES(6), .POS_W(16), .ACC_W(12)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [95:0] pos;
    logic [47:0] vel;
    logic [47:0] cnt;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_e;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic flip(input int dev, input logic [7:0] d);
    bus.spinner[dev*16 +: 8] = d;
    bus.spinner[dev*16+8]    = ~bus.spinner[dev*16+8];
  endtask

  task automatic frame(input frame_t e);
    exp_q.push_back(e);
    bus.vs = 1'b1;
    tick();
    bus.vs = 1'b0;
    repeat (4) tick();
  endtask

  always @(negedge clk_sys) begin
    if (bus.frame_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 128'd1, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        for (int d = 0; d < 6; d++) begin
          chk($sformatf("pos_dev%0d", d), 128'(bus.position[d*16 +: 16]), 128'(mon_e.pos[d*16 +: 16]));
          chk($sformatf("vel_dev%0d", d), 128'(bus.velocity[d*8 +: 8]), 128'(mon_e.vel[d*8 +: 8]));
          chk($sformatf("cnt_dev%0d", d), 128'(bus.evcount[d*8 +: 8]), 128'(mon_e.cnt[d*8 +: 8]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    bus.spinner = '0;
    bus.spinner[8] = 1'b1;
    bus.vs      = 1'b0;
    bus.clear   = '0;
    repeat (3) tick();
    chk("rst_position", 128'(bus.position), 128'd0);
    chk("rst_velocity", 128'(bus.velocity), 128'd0);
    chk("rst_evcount", 128'(bus.evcount), 128'd0);
    chk("rst_strobe", 128'(bus.frame_strobe), 128'd0);

    reset_n = 1'b1;
    repeat (3) tick();
    chk("arm_pos_dev0", 128'(bus.position[15:0]), 128'h0);
    frame('{pos: 96'h0, vel: 48'h0, cnt: 48'h0});

    flip(0, 8'd5);  tick();
    flip(0, 8'd5);  tick();
    flip(0, 8'hFD); tick();
    exp_q.push_back('{pos: {80'h0, 16'h0007}, vel: {40'h0, 8'h07}, cnt: {40'h0, 8'h03}});
    bus.vs = 1'b1;
    tick();
    chk("latch_vel_dev0", 128'(bus.velocity[7:0]), 128'h07);
    chk("strobe_not_yet", 128'(bus.frame_strobe), 128'd0);
    bus.vs = 1'b0;
    tick();
    chk("strobe_high", 128'(bus.frame_strobe), 128'd1);
    tick();
    chk("strobe_one_cycle", 128'(bus.frame_strobe), 128'd0);
    tick();

    for (int i = 0; i < 20; i++) begin
      flip(1, 8'd100);
      tick();
    end
    flip(2, 8'hFF); tick();
    chk("wrap_pos_dev2", 128'(bus.position[47:32]), 128'hFFFF);
    bus.clear[2] = 1'b1;
    flip(2, 8'd4); tick();
    bus.clear = '0;
    chk("clear_add_dev2", 128'(bus.position[47:32]), 128'h0004);
    flip(3, 8'd2); tick();
    flip(3, 8'd9);
    frame('{pos: {16'h0, 16'h0, 16'h000B, 16'h0004, 16'h07D0, 16'h0007},
            vel: {8'h00, 8'h00, 8'h02, 8'h03, 8'h7F, 8'h00},
            cnt: {8'h00, 8'h00, 8'h01, 8'h02, 8'h14, 8'h00}});

    frame('{pos: {16'h0, 16'h0, 16'h000B, 16'h0004, 16'h07D0, 16'h0007},
            vel: {16'h0, 8'h09, 24'h0},
            cnt: {16'h0, 8'h01, 24'h0}});

    for (int d = 0; d < 6; d++) flip(d, 8'd1);
    tick();
    frame('{pos: {16'h0001, 16'h0001, 16'h000C, 16'h0005, 16'h07D1, 16'h0008},
            vel: {6{8'h01}},
            cnt: {6{8'h01}}});

    flip(0, 8'd3); tick();
    chk("pre_reset_pos_dev0", 128'(bus.position[15:0]), 128'h000B);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_position", 128'(bus.position), 128'd0);
    chk("async_velocity", 128'(bus.velocity), 128'd0);
    chk("async_evcount", 128'(bus.evcount), 128'd0);
    chk("async_strobe", 128'(bus.frame_strobe), 128'd0);
    bus.spinner[8] = ~bus.spinner[8];
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("stale_tog_pos_dev0", 128'(bus.position[15:0]), 128'h0);
    frame('{pos: 96'h0, vel: 48'h0, cnt: 48'h0});

    repeat (5) tick();
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
